inst_tag_array: RTL and testbench

//  Set-associative instruction-cache tag store for the multithreaded core fetch stage.
//  - Holds tag+valid per way; 1-cycle registered lookup; per-way compare -> Hit/HitWay.
//  - Picks the refill victim way; self-clears valid bits after reset and on Flush (fence.i).

---
 rtl/inst_tag_array_pkg.sv | 29 ++
 rtl/inst_tag_array_if.sv | 43 ++++
 rtl/inst_tag_array_way.sv | 61 ++++++
 rtl/inst_tag_array.sv | 192 +++++++++++++++++++
 tb/tb_inst_tag_array.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_tag_array_pkg.sv
// ----------------------------------------------------------------------------
// inst_tag_pkg
// Shared types and defaults for the instruction-cache tag store.
//   tag_state_t : sweep controller state
//   tag_entry_t : one tag-store entry {valid, tag} at the default tag width
//   way_bits()  : width of a way number (at least one bit)
// Optional feature macro used by the design files: INST_TAG_PARITY_EN.
// ----------------------------------------------------------------------------
package inst_tag_pkg;

    localparam int SETS_DEF  = 128;
    localparam int WAYS_DEF  = 2;
    localparam int TAG_W_DEF = 7;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } tag_state_t;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
    } tag_entry_t;

    function automatic int way_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/inst_tag_array_if.sv
// ----------------------------------------------------------------------------
// inst_tag_array_if
// Lookup / refill / flush signals of the tag store.
//   master : fetch-stage side (drives Enable, Lookup*, WriteTag*, Flush)
//   slave  : tag store side  (drives LookupValid, Hit, HitWay, FillWay, Busy,
//            ParityErr)
// ParityErr is only meaningful when INST_TAG_PARITY_EN is defined.
// ----------------------------------------------------------------------------
interface inst_tag_array_if
    import inst_tag_pkg::*;
#(
    parameter int SETS  = SETS_DEF,
    parameter int WAYS  = WAYS_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = way_bits(WAYS);

    logic             Enable;
    logic [IDX_W-1:0] LookupIndex;
    logic [TAG_W-1:0] LookupTag;
    logic             LookupValid;
    logic             Hit;
    logic [WAY_W-1:0] HitWay;
    logic             WriteTag;
    logic [IDX_W-1:0] WriteIndex;
    logic [TAG_W-1:0] WriteTagVal;
    logic [WAY_W-1:0] FillWay;
    logic             Flush;
    logic             Busy;
    logic             ParityErr;

    modport master (
        output Enable, LookupIndex, LookupTag, WriteTag, WriteIndex, WriteTagVal, Flush,
        input  LookupValid, Hit, HitWay, FillWay, Busy, ParityErr
    );

    modport slave (
        input  Enable, LookupIndex, LookupTag, WriteTag, WriteIndex, WriteTagVal, Flush,
        output LookupValid, Hit, HitWay, FillWay, Busy, ParityErr
    );

endinterface

// File: rtl/inst_tag_array_way.sv
// ----------------------------------------------------------------------------
// inst_tag_way
// Tag RAM of one way: synchronous read port (registered on re_i) and one
// write port. Read and write of the same address on one edge return the old
// contents.
// With INST_TAG_PARITY_EN defined the way also keeps a parity bit per set:
//   wpar_i          parity written together with a refill
//   flush_i/idx     sweep rewrites parity of {valid=0, stored tag}
//   pk_addr_i       combinational peek (tag + parity) for victim selection
//   rpar_o          parity bit registered alongside rtag_o
// ----------------------------------------------------------------------------
module inst_tag_way #(
    parameter int SETS  = 128,
    parameter int TAG_W = 7
) (
    input  logic                    clk,
    input  logic                    re_i,
    input  logic [$clog2(SETS)-1:0] raddr_i,
    output logic [TAG_W-1:0]        rtag_o,
    input  logic                    we_i,
    input  logic [$clog2(SETS)-1:0] waddr_i,
    input  logic [TAG_W-1:0]        wtag_i
`ifdef INST_TAG_PARITY_EN
    ,
    output logic                    rpar_o,
    input  logic                    wpar_i,
    input  logic                    flush_i,
    input  logic [$clog2(SETS)-1:0] flush_idx_i,
    input  logic [$clog2(SETS)-1:0] pk_addr_i,
    output logic [TAG_W-1:0]        pk_tag_o,
    output logic                    pk_par_o
`endif
);
    logic [TAG_W-1:0] mem_q [SETS];
    logic [TAG_W-1:0] rtag_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wtag_i;
        if (re_i) rtag_q <= mem_q[raddr_i];
    end

    assign rtag_o = rtag_q;

`ifdef INST_TAG_PARITY_EN
    logic par_q [SETS];
    logic rpar_q;

    // Refill and sweep never coincide; the sweep keeps the stored tag and only
    // re-derives parity for valid=0.
    always_ff @(posedge clk) begin
        if (we_i)         par_q[waddr_i]     <= wpar_i;
        else if (flush_i) par_q[flush_idx_i] <= ^mem_q[flush_idx_i];
        if (re_i) rpar_q <= par_q[raddr_i];
    end

    assign rpar_o   = rpar_q;
    assign pk_tag_o = mem_q[pk_addr_i];
    assign pk_par_o = par_q[pk_addr_i];
`endif

endmodule

// File: rtl/inst_tag_array.sv
// ----------------------------------------------------------------------------
// inst_tag_array
// Set-associative instruction-cache tag store for the fetch stage.
// Ports:
//   clk     clock, all state on posedge
//   nReset  asynchronous active-low reset
//   bus     inst_tag_array_if.slave: lookup (Enable/LookupIndex/LookupTag ->
//           LookupValid/Hit/HitWay/ParityErr one cycle later), refill
//           (WriteTag/WriteIndex/WriteTagVal into way FillWay), Flush/Busy.
// After reset and on Flush the valid bits are cleared by a SETS-cycle sweep.
// Optional macro INST_TAG_PARITY_EN adds per-way even parity over {valid,tag};
// without it ParityErr is tied low.
//
//  state | meaning
//  IDLE  | lookups and refills serviced normally
//  FLUSH | sweeping valid=0 into set flush_cnt_q; refills dropped, Hit forced 0
// ----------------------------------------------------------------------------
module inst_tag_array
    import inst_tag_pkg::*;
#(
    parameter int SETS  = SETS_DEF,
    parameter int WAYS  = WAYS_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk,
    input  logic             nReset,
    inst_tag_array_if.slave  bus
);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = way_bits(WAYS);

    tag_state_t       state_q, state_d;
    logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             busy;
    logic             refill_en;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAY_W-1:0] rr_q    [SETS];

    logic [WAY_W-1:0] fill_way;
    logic             set_full;

    logic             lk_valid_q;
    logic             lk_busy_q;
    logic [WAYS-1:0]  lk_vrow_q;
    logic [TAG_W-1:0] lk_tag_q;

    logic [TAG_W-1:0] rd_tag [WAYS];
    logic [WAYS-1:0]  rd_ok;
    logic [WAYS-1:0]  pk_ok;
    logic [WAYS-1:0]  match;
    logic [WAY_W-1:0] hit_way;

    // ---------------- sweep controller ----------------
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q     <= FLUSH;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + 1'b1;
                if (flush_cnt_q == IDX_W'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == FLUSH);
    assign refill_en = bus.WriteTag & ~busy;

    // ---------------- valid bits and round-robin pointers ----------------
    // Valid bits are not reset: the sweep that starts at reset clears them.
    always_ff @(posedge clk) begin
        if (busy)           valid_q[flush_cnt_q]              <= '0;
        else if (refill_en) valid_q[bus.WriteIndex][fill_way] <= 1'b1;
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (refill_en && set_full) begin
            rr_q[bus.WriteIndex] <= (WAYS == 1) ? '0 : rr_q[bus.WriteIndex] + 1'b1;
        end
    end

    // Victim: lowest way that is invalid (or fails parity), else round-robin.
    always_comb begin
        fill_way = rr_q[bus.WriteIndex];
        set_full = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!(valid_q[bus.WriteIndex][w] && pk_ok[w])) begin
                fill_way = WAY_W'(w);
                set_full = 1'b0;
            end
        end
    end

    // ---------------- lookup pipeline ----------------
    // Lookup context is captured only on Enable so Hit/HitWay hold otherwise.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            lk_valid_q <= 1'b0;
            lk_busy_q  <= 1'b0;
            lk_vrow_q  <= '0;
            lk_tag_q   <= '0;
        end else begin
            lk_valid_q <= bus.Enable;
            if (bus.Enable) begin
                lk_busy_q <= busy;
                lk_vrow_q <= valid_q[bus.LookupIndex];
                lk_tag_q  <= bus.LookupTag;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
`ifdef INST_TAG_PARITY_EN
        logic             rd_par;
        logic             pk_par;
        logic [TAG_W-1:0] pk_tag;
`endif
        inst_tag_way #(
            .SETS  (SETS),
            .TAG_W (TAG_W)
        ) u_way (
            .clk         (clk),
            .re_i        (bus.Enable),
            .raddr_i     (bus.LookupIndex),
            .rtag_o      (rd_tag[w]),
            .we_i        (refill_en && (fill_way == WAY_W'(w))),
            .waddr_i     (bus.WriteIndex),
            .wtag_i      (bus.WriteTagVal)
`ifdef INST_TAG_PARITY_EN
            ,
            .rpar_o      (rd_par),
            .wpar_i      (~^bus.WriteTagVal),
            .flush_i     (busy),
            .flush_idx_i (flush_cnt_q),
            .pk_addr_i   (bus.WriteIndex),
            .pk_tag_o    (pk_tag),
            .pk_par_o    (pk_par)
`endif
        );
`ifdef INST_TAG_PARITY_EN
        // Stored parity equals ^{valid,tag} for a healthy entry.
        assign rd_ok[w] = ((^{lk_vrow_q[w], rd_tag[w]}) == rd_par);
        assign pk_ok[w] = ((^{valid_q[bus.WriteIndex][w], pk_tag}) == pk_par);
`else
        assign rd_ok[w] = 1'b1;
        assign pk_ok[w] = 1'b1;
`endif
    end

    // Busy gating also keeps HitWay at 0 for lookups issued during the sweep.
    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = ~lk_busy_q & lk_vrow_q[w] & rd_ok[w] & (rd_tag[w] == lk_tag_q);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WAY_W'(w);
        end
    end

    assign bus.LookupValid = lk_valid_q;
    assign bus.Hit         = |match;
    assign bus.HitWay      = hit_way;
    assign bus.FillWay     = fill_way;
    assign bus.Busy        = busy;
`ifdef INST_TAG_PARITY_EN
    assign bus.ParityErr   = lk_valid_q & ~lk_busy_q & ~(&rd_ok);
`else
    assign bus.ParityErr   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_tag_array.sv
// ----------------------------------------------------------------------------
// tb_inst_tag_array
// Self-checking bench for inst_tag_array. Stimulus pushes the expected lookup
// response into a queue; a negedge monitor pops and compares whenever
// LookupValid is due. The reference model keeps per-set entries, round-robin
// pointers and a sweep countdown. Parity scenario runs when
// INST_TAG_PARITY_EN is defined.
// ----------------------------------------------------------------------------
module tb_inst_tag_array;
    import inst_tag_pkg::*;

    localparam int SETS  = SETS_DEF;
    localparam int WAYS  = WAYS_DEF;
    localparam int TAG_W = TAG_W_DEF;
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = way_bits(WAYS);

    logic clk = 1'b0;
    logic nReset;
    always #5 clk = ~clk;

    inst_tag_array_if #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) bus ();

    inst_tag_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    typedef struct {
        int due;
        bit hit;
        int way;
        bit perr;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    tag_entry_t m_ent [SETS][WAYS];
    bit         m_bad [SETS][WAYS];
    int         m_rr  [SETS];
    int         busy_left = 0;
    bit         busy_seen;
    int         busy_cnt;

    function automatic void check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void clear_all();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_ent[s][w].valid = 1'b0;
                m_bad[s][w]       = 1'b0;
            end
    endfunction

    function automatic void predict(input int idx, input int tg,
                                    output bit h, output int hw, output bit pe);
        h = 0; hw = 0; pe = 0;
        if (busy_left > 0) return;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (m_bad[idx][w]) pe = 1;
            else if (m_ent[idx][w].valid && m_ent[idx][w].tag == TAG_W'(tg)) begin
                h  = 1;
                hw = w;
            end
        end
    endfunction

    function automatic void fill_pred(input int idx, output int fw, output bit full);
        fw   = m_rr[idx];
        full = 1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!m_ent[idx][w].valid || m_bad[idx][w]) begin
                fw   = w;
                full = 0;
            end
        end
    endfunction

    // One clock of stimulus; called just after a posedge, returns just after the next.
    task automatic step(input bit en, input int lidx, input int ltag,
                        input bit wr, input int widx, input int wtag, input bit fl);
        exp_t e;
        int   fw;
        bit   full;
        bus.Enable      = en;
        bus.LookupIndex = IDX_W'(lidx);
        bus.LookupTag   = TAG_W'(ltag);
        bus.WriteTag    = wr;
        bus.WriteIndex  = IDX_W'(widx);
        bus.WriteTagVal = TAG_W'(wtag);
        bus.Flush       = fl;
        if (en) begin
            predict(lidx, ltag, e.hit, e.way, e.perr);
            e.due = cyc + 1;
            exp_q.push_back(e);
        end
        fill_pred(widx, fw, full);
        @(negedge clk);
        busy_seen = bus.Busy;
        if (wr && busy_left == 0) check("fill_way", int'(bus.FillWay), fw);
        @(posedge clk);
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            if (wr) begin
                m_ent[widx][fw].valid = 1'b1;
                m_ent[widx][fw].tag   = TAG_W'(wtag);
                m_bad[widx][fw]       = 1'b0;
                if (full) m_rr[widx] = (m_rr[widx] + 1) % WAYS;
            end
            if (fl) begin
                busy_left = SETS;
                clear_all();
            end
        end
        #1;
    endtask

    task automatic lookup(input int idx, input int tg);
        step(1, idx, tg, 0, 0, 0, 0);
    endtask

    task automatic write(input int idx, input int tg);
        step(0, 0, 0, 1, idx, tg, 0);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare Busy every cycle and each due lookup response.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_lv;
        if (nReset) begin
            exp_lv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("busy", int'(bus.Busy), int'(busy_left > 0));
            check("lookup_valid", int'(bus.LookupValid), int'(exp_lv));
            if (exp_lv) begin
                e = exp_q.pop_front();
                if (bus.LookupValid) begin
                    check("hit", int'(bus.Hit), int'(e.hit));
                    check("hit_way", int'(bus.HitWay), e.way);
                    check("parity_err", int'(bus.ParityErr), int'(e.perr));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nReset          = 1'b0;
        bus.Enable      = 1'b0;
        bus.LookupIndex = '0;
        bus.LookupTag   = '0;
        bus.WriteTag    = 1'b0;
        bus.WriteIndex  = '0;
        bus.WriteTagVal = '0;
        bus.Flush       = 1'b0;
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", int'(bus.Busy), 1);
        check("reset_lookup_valid", int'(bus.LookupValid), 0);
        check("reset_hit", int'(bus.Hit), 0);
        check("reset_hit_way", int'(bus.HitWay), 0);
        check("reset_parity_err", int'(bus.ParityErr), 0);
        @(posedge clk);
        #1;
        nReset    = 1'b1;
        busy_left = SETS;
        clear_all();

        // Sweep after reset: lookups miss, refills dropped, Busy for SETS cycles.
        busy_cnt = 0;
        for (int i = 0; i < SETS + 12; i++) begin
            step(1, $urandom_range(0, SETS - 1), $urandom_range(0, 127),
                 (i < SETS) ? 1'($urandom_range(0, 1)) : 1'b0,
                 $urandom_range(0, SETS - 1), $urandom_range(0, 127), 0);
            if (busy_seen) busy_cnt++;
        end
        check("busy_cycles_reset", busy_cnt, SETS);

        // Basic hit / miss.
        write(5, 'h3A);
        lookup(5, 'h3A);
        lookup(5, 'h3B);

        // Victim selection on a full set.
        write(9, 'h11);
        write(9, 'h22);
        write(9, 'h33);
        lookup(9, 'h11);
        lookup(9, 'h22);
        lookup(9, 'h33);

        // Same-edge write and lookup: old contents, then new.
        step(1, 7, 'h05, 1, 7, 'h05, 0);
        lookup(7, 'h05);

        // Flush after filling sets 0..3.
        for (int i = 0; i < 4; i++) write(i, 'h40 + i);
        for (int i = 0; i < 4; i++) lookup(i, 'h40 + i);
        step(0, 0, 0, 0, 0, 0, 1);
        busy_cnt = 0;
        for (int i = 0; i < SETS + 4; i++) begin
            step(1, $urandom_range(0, 3), 'h40 + $urandom_range(0, 3),
                 (i < SETS - 2) ? 1'b1 : 1'b0, $urandom_range(0, 3), 'h40 + $urandom_range(0, 3),
                 (i == 10) ? 1'b1 : 1'b0);
            if (busy_seen) busy_cnt++;
        end
        check("busy_cycles_flush", busy_cnt, SETS);
        for (int i = 0; i < 4; i++) lookup(i, 'h40 + i);
        lookup(5, 'h3A);

`ifdef INST_TAG_PARITY_EN
        // Corrupt way 1 of set 2: it can no longer hit and becomes the victim.
        write(2, 'h15);
        write(2, 'h16);
        dut.g_way[1].u_way.mem_q[2][0] = ~dut.g_way[1].u_way.mem_q[2][0];
        m_ent[2][1].tag[0] = ~m_ent[2][1].tag[0];
        m_bad[2][1]        = 1'b1;
        lookup(2, 'h16);
        lookup(2, 'h15);
        write(2, 'h17);
        lookup(2, 'h17);
        lookup(2, 'h15);
`endif

        // Randomized traffic on a few sets so hits, full sets and RR wrap occur.
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 9) < 7),
                 $urandom_range(0, 7), 'h50 + $urandom_range(0, 5),
                 1'($urandom_range(0, 9) < 4),
                 $urandom_range(0, 7), 'h50 + $urandom_range(0, 5),
                 1'($urandom_range(0, 299) == 0));
        end

        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
